// File: rtl/gtwizard_0_interlaken_pkg.sv
// rtl/gtwizard_0_interlaken_pkg.sv - shared Interlaken meta-frame constants
package gtwizard_0_interlaken_pkg;

    localparam logic [63:0] DEFAULT_SYNC_WORD = 64'h78f678f678f678f6;
    localparam logic [5:0]  STATE_BLOCK_TYPE  = 6'b001010;
    localparam logic [1:0]  CTRL_HEADER       = 2'b10;
    localparam logic [1:0]  DATA_HEADER       = 2'b01;

    // x^58 + x^39 + 1, expressed as state bit indices
    localparam int TAP_HI = 57;
    localparam int TAP_LO = 38;

    localparam int SLOT_SYNC  = 0;
    localparam int SLOT_STATE = 1;

endpackage

// File: rtl/gtwizard_0_scrambler_lfsr64.sv
// rtl/gtwizard_0_scrambler_lfsr64.sv - one 64-bit step of the x^58+x^39+1 scrambler
module gtwizard_0_scrambler_lfsr64
    import gtwizard_0_interlaken_pkg::*;
(
    input  logic [63:0] data,
    input  logic [57:0] state,
    output logic [63:0] scrambled,
    output logic [57:0] next_state
);

    logic [57:0] s;

    // Scrambled bits feed back into the state; the descrambler variant feeds back the input bit instead.
    always_comb begin
        s         = state;
        scrambled = '0;
        for (int i = 0; i < 64; i++) begin
            scrambled[i] = data[i] ^ s[TAP_HI] ^ s[TAP_LO];
            s            = {s[56:0], scrambled[i]};
        end
        next_state = s;
    end

endmodule

// File: rtl/gtwizard_0_metaframe_scrambler.sv
// rtl/gtwizard_0_metaframe_scrambler.sv - TX meta-frame framer and payload scrambler
module gtwizard_0_metaframe_scrambler
    import gtwizard_0_interlaken_pkg::*;
#(
    parameter int          TX_DATA_WIDTH  = 64,
    parameter logic [63:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
    parameter int          META_FRAME_LEN = 16,
    parameter logic [57:0] SCRAMBLER_SEED = 58'h3FFFFFFFFFFFFFF,
    parameter logic [63:0] IDLE_WORD      = 64'h0000000000000000
)
(
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic                     PASSTHROUGH,
    input  logic [TX_DATA_WIDTH-1:0] UNSCRAMBLED_DATA_IN,
    input  logic [1:0]               HEADER_IN,
    input  logic                     DATA_VALID_IN,
    output logic                     DATA_READY_OUT,
    output logic [TX_DATA_WIDTH-1:0] SCRAMBLED_DATA_OUT,
    output logic [1:0]               HEADER_OUT,
    output logic                     FRAME_START_OUT
);

    localparam int SLOT_W = $clog2(META_FRAME_LEN);

    logic [SLOT_W-1:0] slot;
    logic [57:0]       lfsr;
    logic [63:0]       payload_word;
    logic [63:0]       scrambled_word;
    logic [57:0]       lfsr_next;
    logic              slot_is_sync;
    logic              slot_is_state;
    logic              slot_is_last;

    assign payload_word  = DATA_VALID_IN ? UNSCRAMBLED_DATA_IN : IDLE_WORD;
    assign slot_is_sync  = (slot == SLOT_W'(SLOT_SYNC));
    assign slot_is_state = (slot == SLOT_W'(SLOT_STATE));
    assign slot_is_last  = (slot == SLOT_W'(META_FRAME_LEN - 1));

    assign DATA_READY_OUT = SYSTEM_RESET_N & (PASSTHROUGH | (slot > SLOT_W'(SLOT_STATE)));

    gtwizard_0_scrambler_lfsr64 u_scrambler (
        .data       (payload_word),
        .state      (lfsr),
        .scrambled  (scrambled_word),
        .next_state (lfsr_next)
    );

    // Sync and state slots leave the LFSR untouched so the state word matches the first payload word's seed.
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            SCRAMBLED_DATA_OUT <= '0;
            HEADER_OUT         <= 2'b00;
            FRAME_START_OUT    <= 1'b0;
            slot               <= '0;
            lfsr               <= SCRAMBLER_SEED;
        end else if (PASSTHROUGH) begin
            SCRAMBLED_DATA_OUT <= UNSCRAMBLED_DATA_IN;
            HEADER_OUT         <= HEADER_IN;
            FRAME_START_OUT    <= 1'b0;
            slot               <= '0;
        end else begin
            FRAME_START_OUT <= slot_is_sync;
            slot            <= slot_is_last ? '0 : slot + 1'b1;
            if (slot_is_sync) begin
                SCRAMBLED_DATA_OUT <= SYNC_WORD;
                HEADER_OUT         <= CTRL_HEADER;
            end else if (slot_is_state) begin
                SCRAMBLED_DATA_OUT <= {STATE_BLOCK_TYPE, lfsr};
                HEADER_OUT         <= CTRL_HEADER;
            end else begin
                SCRAMBLED_DATA_OUT <= scrambled_word;
                HEADER_OUT         <= DATA_VALID_IN ? HEADER_IN : CTRL_HEADER;
                lfsr               <= lfsr_next;
            end
        end
    end

endmodule

// File: tb/tb_gtwizard_0_metaframe_scrambler.sv
// tb/tb_gtwizard_0_metaframe_scrambler.sv - directed vector bench for the meta-frame scrambler
module tb_gtwizard_0_metaframe_scrambler;

    logic        USER_CLK = 1'b0;
    logic        SYSTEM_RESET_N;
    logic        PASSTHROUGH;
    logic [63:0] UNSCRAMBLED_DATA_IN;
    logic [1:0]  HEADER_IN;
    logic        DATA_VALID_IN;
    logic        DATA_READY_OUT;
    logic [63:0] SCRAMBLED_DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        FRAME_START_OUT;

    gtwizard_0_metaframe_scrambler dut (
        .USER_CLK            (USER_CLK),
        .SYSTEM_RESET_N      (SYSTEM_RESET_N),
        .PASSTHROUGH         (PASSTHROUGH),
        .UNSCRAMBLED_DATA_IN (UNSCRAMBLED_DATA_IN),
        .HEADER_IN           (HEADER_IN),
        .DATA_VALID_IN       (DATA_VALID_IN),
        .DATA_READY_OUT      (DATA_READY_OUT),
        .SCRAMBLED_DATA_OUT  (SCRAMBLED_DATA_OUT),
        .HEADER_OUT          (HEADER_OUT),
        .FRAME_START_OUT     (FRAME_START_OUT)
    );

    always #5 USER_CLK = ~USER_CLK;

    typedef struct {
        logic        pt;
        logic        v;
        logic [63:0] d;
        logic [1:0]  h;
        logic        e_rdy;
        logic [63:0] e_d;
        logic [1:0]  e_h;
        logic        e_fs;
    } vec_t;

    localparam logic [63:0] SYNC = 64'h78f678f678f678f6;
    localparam logic [57:0] SEED = 58'h3FFFFFFFFFFFFFF;

    vec_t        tbl[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_slot   = 0;
    logic [57:0] m_lfsr   = SEED;
    int          split;

    // Stream view of the scrambler: out bit i depends on the scrambled bits 58 and 39 positions earlier.
    function automatic void ref_scramble(input logic [63:0] d, input logic [57:0] s_in,
                                         output logic [63:0] o, output logic [57:0] s_out);
        logic [121:0] hist;
        hist = '0;
        for (int j = 0; j < 58; j++) hist[57 - j] = s_in[j];
        for (int i = 0; i < 64; i++) begin
            o[i]         = d[i] ^ hist[i] ^ hist[i + 19];
            hist[i + 58] = o[i];
        end
        for (int j = 0; j < 58; j++) s_out[j] = hist[121 - j];
    endfunction

    function automatic bit add_vec(input logic pt, input logic v, input logic [63:0] d, input logic [1:0] h);
        vec_t        r;
        logic [63:0] o;
        logic [57:0] ns;
        r.pt = pt; r.v = v; r.d = d; r.h = h;
        r.e_rdy = pt || (m_slot >= 2);
        r.e_fs  = 1'b0;
        if (pt) begin
            r.e_d = d; r.e_h = h; m_slot = 0;
        end else begin
            if (m_slot == 0) begin
                r.e_d = SYNC; r.e_h = 2'b10; r.e_fs = 1'b1;
            end else if (m_slot == 1) begin
                r.e_d = {6'b001010, m_lfsr}; r.e_h = 2'b10;
            end else begin
                ref_scramble(v ? d : 64'h0, m_lfsr, o, ns);
                r.e_d = o; r.e_h = v ? h : 2'b10; m_lfsr = ns;
            end
            m_slot = (m_slot == 15) ? 0 : m_slot + 1;
        end
        tbl.push_back(r);
        return v && r.e_rdy;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic apply(input int i);
        PASSTHROUGH         = tbl[i].pt;
        DATA_VALID_IN       = tbl[i].v;
        UNSCRAMBLED_DATA_IN = tbl[i].d;
        HEADER_IN           = tbl[i].h;
        #1;
        chk("ready", i, 64'(DATA_READY_OUT), 64'(tbl[i].e_rdy));
        @(posedge USER_CLK);
        #1;
        chk("data", i, SCRAMBLED_DATA_OUT, tbl[i].e_d);
        chk("header", i, 64'(HEADER_OUT), 64'(tbl[i].e_h));
        chk("frame_start", i, 64'(FRAME_START_OUT), 64'(tbl[i].e_fs));
        if (i == 1 || i == split + 1) chk("state_word_seed", i, SCRAMBLED_DATA_OUT, 64'h2BFFFFFFFFFFFFFF);
        if (i == 16) chk("second_sync", i, SCRAMBLED_DATA_OUT, SYNC);
    endtask

    initial begin
        logic [63:0] n;
        logic [63:0] k;
        SYSTEM_RESET_N = 1'b0; PASSTHROUGH = 1'b0; DATA_VALID_IN = 1'b0;
        UNSCRAMBLED_DATA_IN = '0; HEADER_IN = 2'b00;

        // Part A: idle frame, incrementing payload, toggled valid, passthrough pulse, stop mid-payload
        for (int c = 0; c < 18; c++) void'(add_vec(1'b0, 1'b0, 64'h0, 2'b00));
        n = 64'd1;
        for (int c = 0; c < 32; c++) if (add_vec(1'b0, 1'b1, n, 2'b01)) n++;
        k = 64'hA5A5_0000_0000_0000;
        for (int c = 0; c < 24; c++) if (add_vec(1'b0, c[0], k, 2'b01)) k++;
        while (m_slot != 7) if (add_vec(1'b0, 1'b1, n, 2'b01)) n++;
        for (int c = 0; c < 5; c++) void'(add_vec(1'b1, 1'b1, 64'hDEADBEEF_0000_0000 + 64'(c), 2'(c)));
        for (int c = 0; c < 20; c++) if (add_vec(1'b0, 1'b1, n, 2'b01)) n++;
        while (m_slot != 5) if (add_vec(1'b0, 1'b1, n, 2'b01)) n++;
        split = tbl.size();

        // Part B: restart after the mid-payload reset
        m_slot = 0; m_lfsr = SEED; n = 64'd100;
        for (int c = 0; c < 20; c++) if (add_vec(1'b0, 1'b1, n, 2'b01)) n++;

        repeat (2) @(posedge USER_CLK);
        #1;
        PASSTHROUGH = 1'b1; DATA_VALID_IN = 1'b1;
        #1;
        chk("rst_data", -1, SCRAMBLED_DATA_OUT, 64'h0);
        chk("rst_header", -1, 64'(HEADER_OUT), 64'h0);
        chk("rst_frame_start", -1, 64'(FRAME_START_OUT), 64'h0);
        chk("rst_ready", -1, 64'(DATA_READY_OUT), 64'h0);
        PASSTHROUGH = 1'b0; DATA_VALID_IN = 1'b0;
        @(negedge USER_CLK);
        SYSTEM_RESET_N = 1'b1;

        for (int i = 0; i < split; i++) apply(i);

        DATA_VALID_IN = 1'b1; UNSCRAMBLED_DATA_IN = 64'h1234; HEADER_IN = 2'b01;
        #2;
        SYSTEM_RESET_N = 1'b0;
        #1;
        chk("async_rst_data", split, SCRAMBLED_DATA_OUT, 64'h0);
        chk("async_rst_header", split, 64'(HEADER_OUT), 64'h0);
        chk("async_rst_frame_start", split, 64'(FRAME_START_OUT), 64'h0);
        chk("async_rst_ready", split, 64'(DATA_READY_OUT), 64'h0);
        @(posedge USER_CLK);
        @(negedge USER_CLK);
        SYSTEM_RESET_N = 1'b1;

        for (int i = split; i < tbl.size(); i++) apply(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
